// File: rtl/seq_det_arb_ctrl_if.sv
// Requester/result bundle for seq_det_arb_ctrl; slave is the controller, master the producer/consumer side.
// Under SEQ_DET_FIRST_POS_EN the bundle also carries res_pos_a.
interface seq_det_arb_ctrl_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W) + 1;

  logic          req0_valid;
  logic [W-1:0]  req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [W-1:0]  req1_data;
  logic          req1_ready;
  logic          res_valid;
  logic          res_id;
  logic [CW-1:0] res_cnt_a;
  logic [CW-1:0] res_cnt_b;
  logic          busy;
`ifdef SEQ_DET_FIRST_POS_EN
  logic [CW-1:0] res_pos_a;
`endif

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, res_valid, res_id, res_cnt_a, res_cnt_b, busy
`ifdef SEQ_DET_FIRST_POS_EN
    , input res_pos_a
`endif
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, res_valid, res_id, res_cnt_a, res_cnt_b, busy
`ifdef SEQ_DET_FIRST_POS_EN
    , output res_pos_a
`endif
  );
endinterface

// File: rtl/seq_det_arb_ctrl.sv
// Round-robin front end sharing one overlapping Moore 4-bit sequence detector between two requesters.
// Optional macro SEQ_DET_FIRST_POS_EN adds res_pos_a (bit index ending the first PAT_A match).
module seq_det_arb_ctrl #(
  parameter int         W     = 8,
  parameter logic [3:0] PAT_A = 4'b1001,
  parameter logic [3:0] PAT_B = 4'b1011
) (
  input logic               clk,
  input logic               reset,
  seq_det_arb_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ZERO     = CW'(0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  logic [1:0]    r_state;
  logic          r_prio1;
  logic [W-1:0]  r_shreg;
  logic          r_id;
  logic [3:0]    r_hist;
  logic [2:0]    r_fill;
  logic [CW-1:0] r_bitcnt;
  logic [CW-1:0] r_cnt_a;
  logic [CW-1:0] r_cnt_b;
  logic          r_res_valid;
  logic          r_res_id;
  logic [CW-1:0] r_res_cnt_a;
  logic [CW-1:0] r_res_cnt_b;
  logic          r_busy;

  logic          w_idle;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept;
  logic [1:0]    w_state_nxt;
  logic          w_count_en;
  logic          w_match_a;
  logic          w_match_b;
  logic [CW-1:0] w_cnt_a_nxt;
  logic [CW-1:0] w_cnt_b_nxt;

`ifdef SEQ_DET_FIRST_POS_EN
  logic [CW-1:0] r_pos_a;
  logic [CW-1:0] r_res_pos_a;
  logic [CW-1:0] w_pos_a_nxt;
`endif

  // Ready is combinational in IDLE; held low while reset is asserted so nothing is accepted then.
  always_comb begin
    w_idle   = (r_state == ST_IDLE) && !reset;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_idle) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant0 = !r_prio1;
        w_grant1 = r_prio1;
      end else begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid;
      end
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
    w_accept = w_grant0 || w_grant1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SHIFT;
        else          w_state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        if (r_bitcnt == LAST_BIT) w_state_nxt = ST_FLUSH;
        else                      w_state_nxt = ST_SHIFT;
      end
      ST_FLUSH:  w_state_nxt = ST_RESULT;
      ST_RESULT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore match decode: history registered in the previous cycle is counted in this one.
  always_comb begin
    w_count_en  = (r_state == ST_SHIFT) || (r_state == ST_FLUSH);
    w_match_a   = (r_fill == 3'd4) && (r_hist == PAT_A);
    w_match_b   = (r_fill == 3'd4) && (r_hist == PAT_B);
    w_cnt_a_nxt = r_cnt_a + ((w_count_en && w_match_a) ? ONE : ZERO);
    w_cnt_b_nxt = r_cnt_b + ((w_count_en && w_match_b) ? ONE : ZERO);
  end

`ifdef SEQ_DET_FIRST_POS_EN
  // r_bitcnt is the number of bits already in history, so the matching bit sits at r_bitcnt-1.
  always_comb begin
    w_pos_a_nxt = r_pos_a;
    if (w_count_en && w_match_a && (r_pos_a == {CW{1'b1}})) begin
      w_pos_a_nxt = r_bitcnt - ONE;
    end else begin
      w_pos_a_nxt = r_pos_a;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prio1     <= 1'b0;
      r_shreg     <= {W{1'b0}};
      r_id        <= 1'b0;
      r_hist      <= 4'd0;
      r_fill      <= 3'd0;
      r_bitcnt    <= ZERO;
      r_cnt_a     <= ZERO;
      r_cnt_b     <= ZERO;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_cnt_a <= ZERO;
      r_res_cnt_b <= ZERO;
      r_busy      <= 1'b0;
`ifdef SEQ_DET_FIRST_POS_EN
      r_pos_a     <= {CW{1'b1}};
      r_res_pos_a <= ZERO;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_res_valid <= (r_state == ST_FLUSH);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shreg  <= w_grant1 ? bus.req1_data : bus.req0_data;
            r_id     <= w_grant1;
            r_prio1  <= w_grant0;
            r_hist   <= 4'd0;
            r_fill   <= 3'd0;
            r_bitcnt <= ZERO;
            r_cnt_a  <= ZERO;
            r_cnt_b  <= ZERO;
`ifdef SEQ_DET_FIRST_POS_EN
            r_pos_a  <= {CW{1'b1}};
`endif
          end
        end
        ST_SHIFT: begin
          r_shreg  <= {r_shreg[W-2:0], 1'b0};
          r_hist   <= {r_hist[2:0], r_shreg[W-1]};
          r_fill   <= (r_fill == 3'd4) ? 3'd4 : (r_fill + 3'd1);
          r_bitcnt <= r_bitcnt + ONE;
          r_cnt_a  <= w_cnt_a_nxt;
          r_cnt_b  <= w_cnt_b_nxt;
`ifdef SEQ_DET_FIRST_POS_EN
          r_pos_a  <= w_pos_a_nxt;
`endif
        end
        ST_FLUSH: begin
          r_cnt_a     <= w_cnt_a_nxt;
          r_cnt_b     <= w_cnt_b_nxt;
          r_res_id    <= r_id;
          r_res_cnt_a <= w_cnt_a_nxt;
          r_res_cnt_b <= w_cnt_b_nxt;
`ifdef SEQ_DET_FIRST_POS_EN
          r_pos_a     <= w_pos_a_nxt;
          r_res_pos_a <= w_pos_a_nxt;
`endif
        end
        ST_RESULT: begin
          r_id <= r_id;
        end
        default: begin
          r_id <= r_id;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_id     = r_res_id;
  assign bus.res_cnt_a  = r_res_cnt_a;
  assign bus.res_cnt_b  = r_res_cnt_b;
  assign bus.busy       = r_busy;
`ifdef SEQ_DET_FIRST_POS_EN
  assign bus.res_pos_a  = r_res_pos_a;
`endif

endmodule

// File: doc/seq_det_arb_ctrl.md
Name: seq_det_arb_ctrl

Overview:
- Controller that shares one overlapping Moore 4-bit sequence detector between two requesters.
- Each requester hands over a W-bit word. The block round-robin arbitrates, serialises the granted word MSB-first into the detector, and counts hits of two patterns.
- It returns one result record per word.
- Sits between parallel producers and the serial pattern-detection datapath.

Parameters:
W, 8, word width in bits (>=4)
PAT_A, 4'b1001, pattern A, first-received bit is the MSB
PAT_B, 4'b1011, pattern B, first-received bit is the MSB
CW, $clog2(W)+1, match-count width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 has a word
req0_data  in  W  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  W  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
res_valid  out  1  one-cycle result strobe
res_id  out  1  requester that owns the result
res_cnt_a  out  CW  PAT_A matches in the word
res_cnt_b  out  CW  PAT_B matches in the word
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - All outputs 0 (res_valid, res_id, res_cnt_a, res_cnt_b, busy; ready signals 0).
  - Round-robin pointer gives req0 priority.
  - Shift register, bit counter, history, match counters cleared.
- FSM states: IDLE, SHIFT, FLUSH, RESULT.
  - IDLE -> SHIFT on accept.
  - SHIFT -> FLUSH after W shift cycles.
  - FLUSH -> RESULT.
  - RESULT -> IDLE.
- Arbitration:
  - In IDLE, reqN_ready is combinational: high only for the winner among valid requesters.
  - Accept = valid & ready.
  - Both requesters valid: grant the one not granted last; the pointer updates on accept.
  - One requester valid: it wins regardless of the pointer.
  - ready is never high outside IDLE.
- Requester rules:
  - A requester holds data stable while valid and not yet accepted.
  - Dropping valid before accept is legal; nothing is recorded.
- On accept:
  - Latch data and owner id.
  - Clear 4-bit history, history-fill count, bit counter, and both match counters.
- SHIFT:
  - One bit per cycle, MSB first, into history: hist <= {hist[2:0], bit}.
  - Fill count saturates at 4.
- Moore detection:
  - match_a = (fill==4 && hist==PAT_A); match_b likewise with PAT_B. Both decode registered state only.
  - Counters increment on the edge after the bit that completes the match is registered.
  - FLUSH exists so the final bit's match is counted.
- Overlap: matches are overlapping within a word (e.g. 1001001 gives two PAT_A hits). History never carries across words.
- Count range: 0..W-3, so CW bits never overflow.
- RESULT:
  - res_valid=1 for exactly one cycle.
  - res_id, res_cnt_a, res_cnt_b hold until the next RESULT.
  - No backpressure on the result path.
- Latency: accept edge = cycle 0; res_valid high during cycle W+2. Next accept possible at earliest in cycle W+3.
- Reset mid-operation (any state): abandon the word, no res_valid, return to IDLE with req0 priority.
- PAT_A == PAT_B is legal: both counters are equal.

Optional Feature:
- Macro SEQ_DET_FIRST_POS_EN.
- Defined:
  - Adds output res_pos_a [CW-1:0]: bit index (0 = first bit shifted) of the last bit of the first PAT_A match in the word.
  - All-ones if there is no match.
  - Valid with res_valid, same reset and hold rules as the counts.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then req0 8'b1001_0010 -> req0_ready one cycle; res_valid in cycle 10 after accept; id=0, cnt_a=2, cnt_b=0.
- req1 8'b1011_0110 -> id=1, cnt_a=0, cnt_b=2.
- req0 8'b1011_1001 -> cnt_a=1, cnt_b=1. Then 8'b1111_1111 -> cnt_a=0, cnt_b=0.
- Both valid in the same cycle after reset -> req0 granted first, req1 granted in the IDLE cycle after the first RESULT; results ordered id 0 then 1. Then both valid again -> req0 wins (last grant was req1).
- reset asserted during SHIFT bit 5 -> no res_valid, busy=0 next cycle. Re-sent 8'b1001_0010 -> cnt_a=2 (no stale history).
- With SEQ_DET_FIRST_POS_EN: 8'b1001_0010 -> res_pos_a=3; 8'b1111_1111 -> res_pos_a=4'b1111.
